// File: rtl/match_judge.sv
// Match-level result tracker: judges rounds, keeps the win tally and
// declares a match winner at first-to-N wins or at the round limit.
module match_judge #(
   parameter int SCORE_W     = 8,
   parameter int WINS_NEEDED = 3,
   parameter int ROUND_LIMIT = 7,
   parameter int DRAW_POLICY = 0,
   localparam int CNT_W      = $clog2(ROUND_LIMIT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] my_score,
   input  logic [SCORE_W-1:0] op_score,
   input  logic               round_end,
   input  logic               new_match,
   output logic [6:0]         winner,
   output logic [6:0]         match_winner,
   output logic [CNT_W-1:0]   my_wins,
   output logic [CNT_W-1:0]   op_wins,
   output logic [CNT_W-1:0]   rounds,
   output logic               result_valid,
   output logic               match_over
);

   localparam logic [6:0] ASC_NONE = 7'h30;
   localparam logic [6:0] ASC_ME   = 7'h31;
   localparam logic [6:0] ASC_OP   = 7'h32;
   localparam logic [6:0] ASC_DRAW = 7'h33;

   typedef enum logic {PLAY, OVER} state_t;

   state_t           state_q, state_d;
   logic [6:0]       winner_q, winner_d;
   logic [6:0]       match_winner_q, match_winner_d;
   logic [CNT_W-1:0] my_wins_q, my_wins_d;
   logic [CNT_W-1:0] op_wins_q, op_wins_d;
   logic [CNT_W-1:0] rounds_q, rounds_d;
   logic             result_valid_q, result_valid_d;

   logic             accept, my_gt, op_gt;
   logic             my_inc, op_inc;
   logic             my_done, op_done, at_limit, decided;
   logic [CNT_W-1:0] my_nxt, op_nxt, rnd_nxt;
   logic [6:0]       verdict;

   // Round judgement and match decision on the post-increment tally
   always_comb begin
      my_gt    = my_score > op_score;
      op_gt    = op_score > my_score;
      accept   = (state_q == PLAY) && round_end && !new_match;
      my_inc   = my_gt || (!op_gt && DRAW_POLICY == 1);
      op_inc   = op_gt || (!my_gt && DRAW_POLICY == 1);
      my_nxt   = my_wins_q + CNT_W'(my_inc);
      op_nxt   = op_wins_q + CNT_W'(op_inc);
      rnd_nxt  = rounds_q + CNT_W'(1'b1);
      my_done  = my_nxt >= CNT_W'(WINS_NEEDED);
      op_done  = op_nxt >= CNT_W'(WINS_NEEDED);
      at_limit = rnd_nxt == CNT_W'(ROUND_LIMIT);
      decided  = accept && (my_done || op_done || at_limit);
      verdict  = ASC_NONE;
      if (my_done && op_done)  verdict = ASC_DRAW;
      else if (my_done)        verdict = ASC_ME;
      else if (op_done)        verdict = ASC_OP;
      else if (my_nxt > op_nxt) verdict = ASC_ME;
      else if (op_nxt > my_nxt) verdict = ASC_OP;
      else                     verdict = ASC_DRAW;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= PLAY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (new_match)    state_d = PLAY;
      else if (decided) state_d = OVER;
   end

   always_comb begin
      winner_d       = winner_q;
      match_winner_d = match_winner_q;
      my_wins_d      = my_wins_q;
      op_wins_d      = op_wins_q;
      rounds_d       = rounds_q;
      result_valid_d = 1'b0;
      if (new_match) begin
         winner_d       = ASC_NONE;
         match_winner_d = ASC_NONE;
         my_wins_d      = '0;
         op_wins_d      = '0;
         rounds_d       = '0;
      end else if (accept) begin
         if (my_gt)      winner_d = ASC_ME;
         else if (op_gt) winner_d = ASC_OP;
         else            winner_d = ASC_DRAW;
         my_wins_d      = my_nxt;
         op_wins_d      = op_nxt;
         rounds_d       = rnd_nxt;
         result_valid_d = 1'b1;
         if (decided) match_winner_d = verdict;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         winner_q       <= ASC_NONE;
         match_winner_q <= ASC_NONE;
         my_wins_q      <= '0;
         op_wins_q      <= '0;
         rounds_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         winner_q       <= winner_d;
         match_winner_q <= match_winner_d;
         my_wins_q      <= my_wins_d;
         op_wins_q      <= op_wins_d;
         rounds_q       <= rounds_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign winner       = winner_q;
   assign match_winner = match_winner_q;
   assign my_wins      = my_wins_q;
   assign op_wins      = op_wins_q;
   assign rounds       = rounds_q;
   assign result_valid = result_valid_q;
   assign match_over   = (state_q == OVER);

endmodule
